sdram_axi_master: RTL and testbench

AXI4 initiator that turns single-request burst commands from the cache/DMA side into AXI4 INCR read or write bursts toward the SDRAM AXI slave. It is the master-side counterpart of the SDRAM AXI port. It has these responsibilities:
- owns all address/data/response handshakes;
- counts beats and generates `wlast`;
- checks `rlast`;
- reports one completion status per request.

Only one transaction is outstanding at a time.

---
 rtl/sdram_axi_master.sv | 227 ++++++++++++++++++++++
 tb/tb_sdram_axi_master.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_axi_master.sv
// Single-outstanding AXI4 INCR burst initiator for the SDRAM AXI port.
// Optional macro SDRAM_AXI_MASTER_ALIGN_CHECK_EN: reject misaligned or 4 KB-crossing requests.
module sdram_axi_master #(
  parameter logic [3:0] AXI_ID  = 4'h0,
  parameter int         MAX_LEN = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic        wbeat_valid,
  output logic        wbeat_ready,
  input  logic [31:0] wbeat_data,
  input  logic [3:0]  wbeat_strb,
  output logic        rbeat_valid,
  input  logic        rbeat_ready,
  output logic [31:0] rbeat_data,
  output logic        rbeat_last,
  output logic        done_valid,
  output logic        done_err,
  output logic        out_awvalid,
  input  logic        out_awready,
  output logic [31:0] out_awaddr,
  output logic [3:0]  out_awid,
  output logic [7:0]  out_awlen,
  output logic [2:0]  out_awsize,
  output logic [1:0]  out_awburst,
  output logic        out_awlock,
  output logic [3:0]  out_awcache,
  output logic [2:0]  out_awprot,
  output logic [3:0]  out_awqos,
  output logic        out_wvalid,
  input  logic        out_wready,
  output logic [31:0] out_wdata,
  output logic [3:0]  out_wstrb,
  output logic        out_wlast,
  input  logic        out_bvalid,
  output logic        out_bready,
  input  logic [1:0]  out_bresp,
  input  logic [3:0]  out_bid,
  output logic        out_arvalid,
  input  logic        out_arready,
  output logic [31:0] out_araddr,
  output logic [3:0]  out_arid,
  output logic [7:0]  out_arlen,
  output logic [2:0]  out_arsize,
  output logic [1:0]  out_arburst,
  output logic        out_arlock,
  output logic [3:0]  out_arcache,
  output logic [2:0]  out_arprot,
  output logic [3:0]  out_arqos,
  input  logic        out_rvalid,
  output logic        out_rready,
  input  logic [31:0] out_rdata,
  input  logic [1:0]  out_rresp,
  input  logic        out_rlast,
  input  logic [3:0]  out_rid
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_RDATA, S_WRITE, S_BRESP, S_DONE} state_t;

  localparam logic [7:0] MAX_LEN_L = 8'(MAX_LEN);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        reject;
  logic        r_hs, w_hs, aw_hs;

  assign out_awaddr  = addr_q;
  assign out_araddr  = addr_q;
  assign out_awlen   = len_q;
  assign out_arlen   = len_q;
  assign out_awid    = AXI_ID;
  assign out_arid    = AXI_ID;
  assign out_awsize  = 3'b010;
  assign out_arsize  = 3'b010;
  assign out_awburst = 2'b01;
  assign out_arburst = 2'b01;
  assign out_awlock  = 1'b0;
  assign out_arlock  = 1'b0;
  assign out_awcache = 4'b0011;
  assign out_arcache = 4'b0011;
  assign out_awprot  = 3'b000;
  assign out_arprot  = 3'b000;
  assign out_awqos   = 4'h0;
  assign out_arqos   = 4'h0;

  always_comb begin
`ifdef SDRAM_AXI_MASTER_ALIGN_CHECK_EN
    reject = (req_addr[1:0] != 2'b00) ||
             ((11'(req_addr[11:2]) + 11'(req_len)) > 11'd1023);
`else
    reject = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    req_ready   = 1'b0;
    out_arvalid = 1'b0;
    out_awvalid = 1'b0;
    out_wvalid  = 1'b0;
    out_wdata   = '0;
    out_wstrb   = '0;
    out_wlast   = 1'b0;
    wbeat_ready = 1'b0;
    out_rready  = 1'b0;
    rbeat_valid = 1'b0;
    rbeat_data  = '0;
    rbeat_last  = 1'b0;
    out_bready  = 1'b0;
    done_valid  = 1'b0;
    done_err    = 1'b0;
    r_hs        = 1'b0;
    w_hs        = 1'b0;
    aw_hs       = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d = req_addr;
          if (req_len > MAX_LEN_L) begin
            len_d = MAX_LEN_L;
            err_d = 1'b1;
          end else begin
            len_d = req_len;
          end
          if (reject) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = req_write ? S_WRITE : S_AR;
          end
        end
      end
      S_AR: begin
        out_arvalid = 1'b1;
        if (out_arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        out_rready  = rbeat_ready;
        rbeat_valid = out_rvalid;
        rbeat_data  = out_rdata;
        rbeat_last  = out_rlast;
        r_hs        = out_rvalid && rbeat_ready;
        if (r_hs) begin
          cnt_d = cnt_q + 8'd1;
          // A misplaced or missing rlast only marks the status; the burst still runs len+1 beats.
          if ((out_rresp != 2'b00) || (out_rid != AXI_ID) || (out_rlast != (cnt_q == len_q)))
            err_d = 1'b1;
          if (cnt_q == len_q) state_d = S_DONE;
        end
      end
      S_WRITE: begin
        out_awvalid = !aw_done_q;
        aw_hs       = !aw_done_q && out_awready;
        if (aw_hs) aw_done_d = 1'b1;
        if (!w_done_q) begin
          out_wvalid  = wbeat_valid;
          wbeat_ready = out_wready;
          out_wdata   = wbeat_data;
          out_wstrb   = wbeat_strb;
          out_wlast   = (cnt_q == len_q);
          w_hs        = wbeat_valid && out_wready;
        end
        if (w_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && (cnt_q == len_q))))
          state_d = S_BRESP;
      end
      S_BRESP: begin
        out_bready = 1'b1;
        if (out_bvalid) begin
          if ((out_bresp != 2'b00) || (out_bid != AXI_ID)) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_valid = 1'b1;
        done_err   = err_q;
        state_d    = S_IDLE;
        err_d      = 1'b0;
        cnt_d      = '0;
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_sdram_axi_master.sv
// Bench for sdram_axi_master: randomized slave/source traffic checked every cycle against a burst-level model.
`timescale 1ns/1ps
module tb_sdram_axi_master;
  localparam logic [3:0] ID   = 4'h0;
  localparam int         MAXL = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        wbeat_valid, wbeat_ready;
  logic [31:0] wbeat_data;
  logic [3:0]  wbeat_strb;
  logic        rbeat_valid, rbeat_ready, rbeat_last;
  logic [31:0] rbeat_data;
  logic        done_valid, done_err;
  logic        out_awvalid, out_awready, out_awlock, out_arlock;
  logic [31:0] out_awaddr, out_araddr;
  logic [3:0]  out_awid, out_arid, out_awcache, out_arcache, out_awqos, out_arqos;
  logic [7:0]  out_awlen, out_arlen;
  logic [2:0]  out_awsize, out_arsize, out_awprot, out_arprot;
  logic [1:0]  out_awburst, out_arburst;
  logic        out_wvalid, out_wready, out_wlast;
  logic [31:0] out_wdata;
  logic [3:0]  out_wstrb;
  logic        out_bvalid, out_bready;
  logic [1:0]  out_bresp;
  logic [3:0]  out_bid;
  logic        out_arvalid, out_arready;
  logic        out_rvalid, out_rready, out_rlast;
  logic [31:0] out_rdata;
  logic [1:0]  out_rresp;
  logic [3:0]  out_rid;

  always #5 clock = ~clock;

  sdram_axi_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wbeat_valid(wbeat_valid), .wbeat_ready(wbeat_ready), .wbeat_data(wbeat_data), .wbeat_strb(wbeat_strb),
    .rbeat_valid(rbeat_valid), .rbeat_ready(rbeat_ready), .rbeat_data(rbeat_data), .rbeat_last(rbeat_last),
    .done_valid(done_valid), .done_err(done_err),
    .out_awvalid(out_awvalid), .out_awready(out_awready), .out_awaddr(out_awaddr), .out_awid(out_awid),
    .out_awlen(out_awlen), .out_awsize(out_awsize), .out_awburst(out_awburst), .out_awlock(out_awlock),
    .out_awcache(out_awcache), .out_awprot(out_awprot), .out_awqos(out_awqos),
    .out_wvalid(out_wvalid), .out_wready(out_wready), .out_wdata(out_wdata), .out_wstrb(out_wstrb),
    .out_wlast(out_wlast),
    .out_bvalid(out_bvalid), .out_bready(out_bready), .out_bresp(out_bresp), .out_bid(out_bid),
    .out_arvalid(out_arvalid), .out_arready(out_arready), .out_araddr(out_araddr), .out_arid(out_arid),
    .out_arlen(out_arlen), .out_arsize(out_arsize), .out_arburst(out_arburst), .out_arlock(out_arlock),
    .out_arcache(out_arcache), .out_arprot(out_arprot), .out_arqos(out_arqos),
    .out_rvalid(out_rvalid), .out_rready(out_rready), .out_rdata(out_rdata), .out_rresp(out_rresp),
    .out_rlast(out_rlast), .out_rid(out_rid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Burst-level model of the current request (written by the driver before the request is raised)
  bit          m_write, m_reject, m_err, m_toggle;
  logic [31:0] m_addr;
  logic [7:0]  m_req_len;
  int          m_len, m_pct, m_aw_delay;
  logic [31:0] m_data  [0:63];
  logic [3:0]  m_strb  [0:63];
  logic [1:0]  m_rresp [0:63];
  logic [3:0]  m_rid   [0:63];
  logic        m_rlast [0:63];
  logic [1:0]  m_bresp;
  logic [3:0]  m_bid;

  // Observation state (written by the checker only)
  bit          hs_req, hs_ar, hs_aw, hs_w, hs_r, hs_b, hs_done;
  bit          c_busy, exp_done;
  int          ar_cnt, aw_cnt, w_idx, r_idx, b_cnt, done_cnt;
  logic        last_err;
  logic [7:0]  last_arlen, last_awlen;
  logic [31:0] last_rdata;

  localparam logic [41:0] AXI_CONST = {3'b010, 3'b010, 2'b01, 2'b01, 1'b0, 1'b0,
                                       4'b0011, 4'b0011, 3'b000, 3'b000, 4'h0, 4'h0, ID, ID};

  always @(negedge clock) begin
    bit wph, rph;
    hs_req = 0; hs_ar = 0; hs_aw = 0; hs_w = 0; hs_r = 0; hs_b = 0; hs_done = 0;
    check("axi_constants", {out_awsize, out_arsize, out_awburst, out_arburst, out_awlock, out_arlock,
          out_awcache, out_arcache, out_awprot, out_arprot, out_awqos, out_arqos, out_awid, out_arid}, AXI_CONST);
    if (!reset) begin
      check("reset_outputs", {req_ready, out_arvalid, out_awvalid, out_wvalid, wbeat_ready, rbeat_valid,
            out_rready, out_bready, done_valid}, 9'b1_0000_0000);
      c_busy = 0; exp_done = 0; ar_cnt = 0; aw_cnt = 0; w_idx = 0; r_idx = 0; b_cnt = 0;
    end else begin
      wph = c_busy && m_write && !m_reject && (w_idx <= m_len);
      rph = c_busy && !m_write && !m_reject && (ar_cnt == 1) && (r_idx <= m_len);
      check("req_ready", req_ready, !c_busy);
      check("done_timing", done_valid, exp_done);
      check("arvalid", out_arvalid, c_busy && !m_write && !m_reject && (ar_cnt == 0));
      check("awvalid", out_awvalid, c_busy && m_write && !m_reject && (aw_cnt == 0));
      check("wvalid", out_wvalid, wph && wbeat_valid);
      check("wbeat_ready", wbeat_ready, wph && out_wready);
      check("rbeat_valid", rbeat_valid, rph && out_rvalid);
      check("rready", out_rready, rph && rbeat_ready);
      check("bready", out_bready, c_busy && m_write && !m_reject && (aw_cnt == 1) &&
            (w_idx == m_len + 1) && (b_cnt == 0));
      exp_done = 0;
      if (out_arvalid) check("ar_addr_len", {out_araddr, out_arlen}, {m_addr, 8'(m_len)});
      if (out_awvalid) check("aw_addr_len", {out_awaddr, out_awlen}, {m_addr, 8'(m_len)});
      if (out_arvalid && out_arready) begin ar_cnt++; hs_ar = 1; last_arlen = out_arlen; end
      if (out_awvalid && out_awready) begin aw_cnt++; hs_aw = 1; last_awlen = out_awlen; end
      if (out_wvalid && out_wready) begin
        check("w_beat", {out_wdata, out_wstrb, out_wlast},
              {m_data[w_idx & 63], m_strb[w_idx & 63], 1'(w_idx == m_len)});
        w_idx++;
      end
      if (wbeat_valid && wbeat_ready) hs_w = 1;
      if (out_rvalid && out_rready) hs_r = 1;
      if (rbeat_valid && rbeat_ready) begin
        check("r_beat", {rbeat_data, rbeat_last}, {m_data[r_idx & 63], m_rlast[r_idx & 63]});
        last_rdata = rbeat_data;
        if (r_idx == m_len) exp_done = 1;
        r_idx++;
      end
      if (out_bvalid && out_bready) begin hs_b = 1; b_cnt++; exp_done = 1; end
      if (done_valid) begin
        check("done_err", done_err, m_err);
        $display("txn %0d: %s addr=0x%08h len=%0d done_err=%0b", done_cnt, m_write ? "WR" : "RD",
                 m_addr, m_req_len, done_err);
        last_err = done_err; done_cnt++; hs_done = 1; c_busy = 0;
      end
      if (req_valid && req_ready) begin
        hs_req = 1; c_busy = 1; ar_cnt = 0; aw_cnt = 0; w_idx = 0; r_idx = 0; b_cnt = 0;
        exp_done = m_reject;
      end
    end
  end

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic zero_inputs();
    req_valid = 0; req_write = 0; req_addr = '0; req_len = '0;
    wbeat_valid = 0; wbeat_data = '0; wbeat_strb = '0; rbeat_ready = 0;
    out_awready = 0; out_wready = 0; out_arready = 0;
    out_bvalid = 0; out_bresp = '0; out_bid = '0;
    out_rvalid = 0; out_rdata = '0; out_rresp = '0; out_rlast = 0; out_rid = '0;
  endtask

  task automatic setup(input bit wr, input logic [31:0] addr, input logic [7:0] len);
    m_write = wr; m_addr = addr; m_req_len = len;
    m_len = (int'(len) > MAXL) ? MAXL : int'(len);
`ifdef SDRAM_AXI_MASTER_ALIGN_CHECK_EN
    m_reject = (addr[1:0] != 2'b00) || (int'(addr[11:2]) + int'(len) > 1023);
`else
    m_reject = 0;
`endif
    for (int k = 0; k < 64; k++) begin
      m_data[k] = $urandom; m_strb[k] = 4'($urandom); m_rresp[k] = 2'b00; m_rid[k] = ID;
      m_rlast[k] = (k == m_len);
    end
    m_bresp = 2'b00; m_bid = ID; m_pct = 100; m_aw_delay = 0; m_toggle = 0;
  endtask

  // Status the request must report, from the slave behaviour chosen for it
  task automatic finalize();
    m_err = (int'(m_req_len) > MAXL) || m_reject;
    if (!m_reject) begin
      if (m_write) begin
        if (m_bresp != 2'b00 || m_bid != ID) m_err = 1;
      end else begin
        for (int k = 0; k <= m_len; k++)
          if (m_rresp[k] != 2'b00 || m_rid[k] != ID || m_rlast[k] != (k == m_len)) m_err = 1;
      end
    end
  endtask

  task automatic execute(input int abort_at);
    int cyc, wi, ri;
    bit ar_d, aw_d, b_d, fin, rv;
    finalize();
    @(posedge clock); #1;
    req_valid = 1; req_write = m_write; req_addr = m_addr; req_len = m_req_len;
    cyc = 0;
    do begin @(posedge clock); #1; cyc++; end while (!hs_req && cyc < 20);
    req_valid = 0;
    if (!hs_req) begin check("req_accept_timeout", 0, 1); return; end
    cyc = 0; wi = 0; ri = 0; ar_d = 0; aw_d = 0; b_d = 0; fin = 0;
    while (!fin) begin
      wbeat_valid = m_write && (wi <= m_len) && pct(m_pct);
      wbeat_data  = m_data[wi & 63];
      wbeat_strb  = m_strb[wi & 63];
      out_awready = (cyc >= m_aw_delay) && pct(m_pct);
      out_arready = (cyc >= m_aw_delay) && pct(m_pct);
      out_wready  = pct(m_pct);
      rv = ar_d && (ri <= m_len) && pct(m_pct);
      out_rvalid = rv;
      out_rdata  = rv ? m_data[ri & 63] : $urandom;
      out_rresp  = rv ? m_rresp[ri & 63] : 2'b00;
      out_rid    = rv ? m_rid[ri & 63] : ID;
      out_rlast  = rv ? m_rlast[ri & 63] : 1'b0;
      rbeat_ready = m_toggle ? cyc[0] : pct(m_pct);
      out_bvalid = m_write && aw_d && (wi > m_len) && !b_d && pct(m_pct);
      out_bresp  = m_bresp;
      out_bid    = m_bid;
      @(posedge clock); #1; cyc++;
      if (hs_w) wi++;
      if (hs_r) ri++;
      if (hs_ar) ar_d = 1;
      if (hs_aw) aw_d = 1;
      if (hs_b) b_d = 1;
      if (hs_done) fin = 1;
      if (abort_at > 0 && ri == abort_at && !fin) begin
        zero_inputs();
        reset = 0;
        #1;
        check("abort_valids_low", {out_arvalid, out_awvalid, out_wvalid, rbeat_valid, out_rready,
              out_bready, done_valid}, 7'b0);
        repeat (2) @(posedge clock);
        #1 reset = 1;
        return;
      end
      if (cyc > 600 && !fin) begin
        check("txn_timeout", 0, 1);
        zero_inputs();
        reset = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1;
        fin = 1;
      end
    end
    zero_inputs();
  endtask

  initial begin
    int dc;
    zero_inputs();
    reset = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1;

    setup(0, 32'h8000_0010, 8'd3);
    for (int k = 0; k < 4; k++) m_data[k] = 32'hA0 + k;
    execute(0);
    check("t1_arlen", last_arlen, 8'd3);
    check("t1_rbeats", r_idx, 4);
    check("t1_last_rdata", last_rdata, 32'hA3);
    check("t1_err", last_err, 1'b0);

    setup(1, 32'h0000_1000, 8'd1);
    m_aw_delay = 5;
    execute(0);
    check("t2_awlen", last_awlen, 8'd1);
    check("t2_err", last_err, 1'b0);

    setup(0, 32'h0000_0100, 8'd3);
    m_rlast[1] = 1'b1;
    execute(0);
    check("t3_early_rlast_err", last_err, 1'b1);
    check("t3_rbeats", r_idx, 4);

    setup(1, 32'h0000_0200, 8'd2);
    m_bresp = 2'b10;
    execute(0);
    check("t4_bresp_err", last_err, 1'b1);

    setup(0, 32'h0000_0300, 8'd7);
    m_toggle = 1;
    execute(0);
    check("toggle_rbeats", r_idx, 8);
    check("toggle_err", last_err, 1'b0);

    setup(1, 32'h0000_0380, 8'd0);
    execute(0);
    check("single_write_err", last_err, 1'b0);

    setup(0, 32'h0000_0400, 8'd20);
    execute(0);
    check("clamp_arlen", last_arlen, 8'd15);
    check("clamp_err", last_err, 1'b1);

    dc = done_cnt;
    setup(0, 32'h0000_0500, 8'd3);
    execute(2);
    check("abort_no_done", done_cnt, dc);
    setup(0, 32'h0000_0600, 8'd2);
    execute(0);
    check("after_abort_err", last_err, 1'b0);
    check("after_abort_dones", done_cnt, dc + 1);

`ifdef SDRAM_AXI_MASTER_ALIGN_CHECK_EN
    setup(0, 32'h8000_0FFC, 8'd1);
    execute(0);
    check("align_err", last_err, 1'b1);
    check("align_no_ar", ar_cnt, 0);
`endif

    for (int t = 0; t < 40; t++) begin
      setup(1'($urandom_range(1)), $urandom & 32'hFFFF_FFFC,
            ($urandom_range(9) == 0) ? 8'($urandom_range(40)) : 8'($urandom_range(MAXL)));
      m_pct = $urandom_range(100, 30);
      m_aw_delay = $urandom_range(6);
      if ($urandom_range(9) == 0) m_bresp = 2'($urandom_range(3, 1));
      if ($urandom_range(9) == 0) m_bid = 4'($urandom_range(15, 1));
      for (int k = 0; k <= m_len; k++) begin
        if ($urandom_range(29) == 0) m_rresp[k] = 2'($urandom_range(3, 1));
        if ($urandom_range(29) == 0) m_rid[k] = 4'($urandom_range(15, 1));
        if ($urandom_range(29) == 0) m_rlast[k] = !m_rlast[k];
      end
      execute(0);
    end

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
